fetch_pc_ctrl: RTL

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

---
 rtl/mycpu_pkg.sv | 37 +++
 rtl/fetch_out_buf.sv | 50 +++++
 rtl/fetch_pc_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU types: jump decision bundle, address type and fetch-side
// definitions used by the instruction fetch PC controller.
package mycpu_pkg;

  typedef logic [31:0] addr_t;

  // Jump kinds produced by decode; J_NOP means "no redirect".
  typedef enum logic [1:0] {
    J_NOP = 2'd0,
    J_REL = 2'd1,
    J_ABS = 2'd2,
    J_REG = 2'd3
  } jmp_stat_t;

  typedef struct packed {
    jmp_stat_t stat;
    addr_t     pc_src;
    addr_t     pc_dst;
  } jmp_pack_t;

  // Fetch request tracker: nothing outstanding, outstanding and wanted,
  // outstanding but its response must be thrown away.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam addr_t FETCH_RESET_PC = 32'hbfc0_0000;
  localparam addr_t INSTR_BYTES    = 32'd4;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic addr_t pc_step(input addr_t pc, input int unsigned n);
    return pc + addr_t'(n * INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry output register between the I-side response and decode.
// Holds its contents while decode stalls, and can be flushed on redirect.
module fetch_out_buf
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  addr_t       load_pc,
  input  logic [31:0] load_instr,
  input  logic        clear,
  input  logic        f_ready,
  output logic        f_valid,
  output addr_t       f_pc,
  output logic [31:0] f_instr,
  output logic        can_issue
);

  logic        valid_reg;
  addr_t       pc_reg;
  logic [31:0] instr_reg;

  // Clear beats load: a response arriving in the redirect cycle is stale.
  // Payload is only rewritten on load, so it stays stable while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end else if (f_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // A new request may go out when the entry is free or draining this cycle.
  always_comb begin
    can_issue = !valid_reg || f_ready;
  end

  assign f_valid = valid_reg;
  assign f_pc    = pc_reg;
  assign f_instr = instr_reg;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Instruction fetch PC controller: one outstanding I-side request, one
// buffered instruction, delayed-slot aware branch redirect and exception
// redirect with discard of in-flight responses.
module fetch_pc_ctrl
  import mycpu_pkg::*;
#(
  parameter addr_t RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  jmp_pack_t   jmp,
  input  logic        jmp_valid,
  input  logic        jmp_delayed,
  input  logic        exc_valid,
  input  addr_t       exc_pc,
  output logic        ireq_valid,
  output addr_t       ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output addr_t       f_pc,
  output logic [31:0] f_instr,
  input  logic        f_ready
);

  fetch_state_t state_reg, state_next;
  addr_t        pc_q, pc_next;
  addr_t        req_pc_reg, req_pc_next;
  logic         redir_pend, redir_pend_next;
  addr_t        redir_pc, redir_pc_next;

  logic  can_issue;
  logic  req_fire;
  logic  jmp_act;
  logic  jmp_now;
  logic  slot_pending;
  logic  slot_issued;
  logic  flush;
  logic  kill_req;
  logic  buf_load;
  addr_t seq_pc;

  // Decode the redirect sources for this cycle; exceptions mask jumps.
  always_comb begin
    jmp_act      = jmp_valid && (jmp.stat != J_NOP) && !exc_valid;
    jmp_now      = jmp_act && !jmp_delayed;
    slot_pending = jmp_act && jmp_delayed && (pc_q == pc_step(jmp.pc_src, 1));
    slot_issued  = jmp_act && jmp_delayed && (pc_q == pc_step(jmp.pc_src, 2));
    flush        = exc_valid || jmp_now;
    // A request accepted in a flush cycle, or the one just past an already
    // requested delay slot, is on the wrong path and must be discarded.
    kill_req     = flush || slot_issued;
    ireq_valid   = !reset && (state_reg == S_IDLE) && can_issue;
    req_fire     = ireq_valid && ireq_ready;
    seq_pc       = redir_pend ? redir_pc : pc_step(pc_q, 1);
    buf_load     = (state_reg == S_BUSY) && iresp_valid && !flush;
  end

  assign ireq_addr = pc_q;

  // Next fetch address and pending delay-slot redirect.
  always_comb begin
    pc_next         = pc_q;
    req_pc_next     = req_pc_reg;
    redir_pend_next = redir_pend;
    redir_pc_next   = redir_pc;

    if (req_fire) begin
      req_pc_next = pc_q;
    end

    if (exc_valid) begin
      pc_next         = exc_pc;
      redir_pend_next = 1'b0;
    end else if (jmp_now) begin
      // An immediate jump supersedes any delay-slot redirect still waiting.
      pc_next         = jmp.pc_dst;
      redir_pend_next = 1'b0;
    end else if (slot_issued) begin
      pc_next = jmp.pc_dst;
    end else if (slot_pending) begin
      if (req_fire) begin
        // Slot goes out right now; the target follows directly.
        pc_next = jmp.pc_dst;
      end else begin
        redir_pend_next = 1'b1;
        redir_pc_next   = jmp.pc_dst;
      end
    end else if (req_fire) begin
      pc_next         = seq_pc;
      redir_pend_next = 1'b0;
    end
  end

  // Request tracker next state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_fire) begin
          state_next = kill_req ? S_DROP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (iresp_valid) begin
          state_next = S_IDLE;
        end else if (flush) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (iresp_valid) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      pc_q       <= RESET_PC;
      req_pc_reg <= RESET_PC;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      state_reg  <= state_next;
      pc_q       <= pc_next;
      req_pc_reg <= req_pc_next;
      redir_pend <= redir_pend_next;
      redir_pc   <= redir_pc_next;
    end
  end

  fetch_out_buf u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .load_pc    (req_pc_reg),
    .load_instr (iresp_data),
    .clear      (flush),
    .f_ready    (f_ready),
    .f_valid    (f_valid),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .can_issue  (can_issue)
  );

endmodule
